// File: rtl/npc_core_seq_if.sv
// Bus bundle between the NPC sequencer and its surroundings: instruction memory,
// data memory and the decode/branch/register-file datapath.
interface npc_core_seq_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            inst_valid;
    logic            dec_load;
    logic            dec_store;
    logic            dec_wen;
    logic            dec_ebreak;
    logic            br_taken;
    logic [XLEN-1:0] br_target;
    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;
    logic [XLEN-1:0] ld_data;
    logic            rf_wen;
    logic            halt;
    logic [1:0]      halt_cause;

    modport master (
        output imem_req, imem_addr, inst, pc, inst_valid,
        output dmem_req, dmem_we, ld_data, rf_wen, halt, halt_cause,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  dec_load, dec_store, dec_wen, dec_ebreak, br_taken, br_target,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, inst, pc, inst_valid,
        input  dmem_req, dmem_we, ld_data, rf_wen, halt, halt_cause,
        output imem_gnt, imem_rvalid, imem_rdata,
        output dec_load, dec_store, dec_wen, dec_ebreak, br_taken, br_target,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/npc_core_seq.sv
// Multi-cycle RV32 sequencer: owns PC/IR, runs the imem/dmem handshakes, commits once per instruction.
// Define NPC_PERF_CNT_EN to add the perf_cycle/perf_instret counters.
module npc_core_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
`ifdef NPC_PERF_CNT_EN
    ,
    parameter int              CNT_W    = 64
`endif
) (
    input  logic clk,
    input  logic rst,
    npc_core_seq_if.master bus
`ifdef NPC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_cycle,
    output logic [CNT_W-1:0] perf_instret
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH,
        S_IWAIT,
        S_EXEC,
        S_MREQ,
        S_MWAIT,
        S_WB,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_seq_pc;
    logic [31:0]     r_inst;
    logic [31:0]     w_inst_next;
    logic [XLEN-1:0] r_ld_data;
    logic [XLEN-1:0] w_ld_data_next;
    logic [1:0]      r_halt_cause;
    logic [1:0]      w_halt_cause_next;
    logic            w_imem_req;
    logic            w_dmem_req;
    logic            w_dmem_we;
    logic            w_inst_valid;
    logic            w_rf_wen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc         <= RESET_PC;
            r_inst       <= NOP;
            r_ld_data    <= '0;
            r_halt_cause <= 2'b00;
        end else begin
            r_pc         <= w_pc_next;
            r_inst       <= w_inst_next;
            r_ld_data    <= w_ld_data_next;
            r_halt_cause <= w_halt_cause_next;
        end
    end

    // Sequential next PC wraps naturally at 2^XLEN.
    assign w_seq_pc = bus.br_taken ? bus.br_target : (r_pc + XLEN'(4));

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_inst_next       = r_inst;
        w_ld_data_next    = r_ld_data;
        w_halt_cause_next = r_halt_cause;
        w_imem_req        = 1'b0;
        w_dmem_req        = 1'b0;
        w_dmem_we         = 1'b0;
        w_inst_valid      = 1'b0;
        w_rf_wen          = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (bus.imem_gnt) w_state_next = S_IWAIT;
            end
            S_IWAIT: begin
                if (bus.imem_rvalid) begin
                    w_inst_next  = bus.imem_rdata;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_inst_valid = 1'b1;
                if (bus.dec_ebreak) begin
                    w_halt_cause_next = 2'b01;
                    w_state_next      = S_HALT;
                end else if (bus.dec_load || bus.dec_store) begin
                    w_state_next = S_MREQ;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MREQ: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = bus.dec_store;
                if (bus.dmem_gnt) w_state_next = S_MWAIT;
            end
            S_MWAIT: begin
                if (bus.dmem_rvalid) begin
                    if (bus.dec_load) w_ld_data_next = bus.dmem_rdata;
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                // The write still commits when the redirect target is misaligned.
                w_rf_wen = bus.dec_wen;
                if (w_seq_pc[1:0] != 2'b00) begin
                    w_halt_cause_next = 2'b10;
                    w_state_next      = S_HALT;
                end else begin
                    w_pc_next    = w_seq_pc;
                    w_state_next = S_FETCH;
                end
            end
            S_HALT: begin
                w_state_next = S_HALT;
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // FETCH is the reset state, so the fetch request is masked while reset is held.
    assign bus.imem_req   = w_imem_req & rst;
    assign bus.imem_addr  = r_pc;
    assign bus.pc         = r_pc;
    assign bus.inst       = r_inst;
    assign bus.inst_valid = w_inst_valid;
    assign bus.dmem_req   = w_dmem_req;
    assign bus.dmem_we    = w_dmem_we;
    assign bus.ld_data    = r_ld_data;
    assign bus.rf_wen     = w_rf_wen;
    assign bus.halt       = (r_state == S_HALT);
    assign bus.halt_cause = r_halt_cause;

`ifdef NPC_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_cycle;
    logic [CNT_W-1:0] r_perf_instret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_cycle   <= '0;
            r_perf_instret <= '0;
        end else if (r_state != S_HALT) begin
            r_perf_cycle <= r_perf_cycle + CNT_W'(1);
            if (r_state == S_WB && w_state_next == S_FETCH) begin
                r_perf_instret <= r_perf_instret + CNT_W'(1);
            end
        end
    end

    assign perf_cycle   = r_perf_cycle;
    assign perf_instret = r_perf_instret;
`endif

endmodule

// File: tb/tb_npc_core_seq.sv
// Self-checking bench for npc_core_seq: an instruction-level model expands each
// instruction into its expected per-cycle outputs, plus directed literal checks.
module tb_npc_core_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    npc_core_seq_if #(.XLEN(32)) bus ();

`ifdef NPC_PERF_CNT_EN
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;
`endif

    npc_core_seq #(
        .XLEN    (32),
        .RESET_PC(RST_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef NPC_PERF_CNT_EN
        ,
        .perf_cycle  (perf_cycle),
        .perf_instret(perf_instret)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;
    bit skip   = 1'b0;

    // Architectural model state
    logic [31:0] m_pc, m_inst, m_ld;
    logic        m_halt;
    logic [1:0]  m_cause;
    logic [63:0] m_cyc, m_ret;

    // Decoder outputs for the instruction currently held in the IR
    logic        d_load, d_store, d_wen, d_ebreak, d_br;
    logic [31:0] d_tgt;

    // Per-cycle record of DUT outputs for literal checks
    logic [31:0] rec_addr [512];
    logic [31:0] rec_pc   [512];
    logic [31:0] rec_ld   [512];
    logic        rec_ireq [512];
    logic        rec_dreq [512];
    logic        rec_rfw  [512];
    logic        rec_halt [512];
    logic [1:0]  rec_cause[512];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
        end
    endtask

    function automatic bit rb(input bit en);
        return en && ($urandom_range(0, 1) == 1);
    endfunction

    task automatic cyc(input string ph, input bit ig, input bit irv, input logic [31:0] ird,
                       input bit dg, input bit drv, input logic [31:0] drd,
                       input bit e_ireq, input bit e_ival, input bit e_dreq, input bit e_we,
                       input bit e_rfw);
        logic [191:0] act, exp;
        if (skip) skip = 1'b0;
        else begin
            @(posedge clk);
            #1;
        end
        bus.imem_gnt    = ig;
        bus.imem_rvalid = irv;
        bus.imem_rdata  = ird;
        bus.dmem_gnt    = dg;
        bus.dmem_rvalid = drv;
        bus.dmem_rdata  = drd;
        bus.dec_load    = d_load;
        bus.dec_store   = d_store;
        bus.dec_wen     = d_wen;
        bus.dec_ebreak  = d_ebreak;
        bus.br_taken    = d_br;
        bus.br_target   = d_tgt;
        @(negedge clk);
        cyc_no++;
        exp = {56'd0, e_ireq, m_pc, m_pc, m_inst, e_ival, e_dreq, e_we, m_ld, e_rfw, m_halt, m_cause};
        act = {56'd0, bus.imem_req, bus.imem_addr, bus.pc, bus.inst, bus.inst_valid, bus.dmem_req,
               bus.dmem_we, bus.ld_data, bus.rf_wen, bus.halt, bus.halt_cause};
        chk(ph, act, exp);
        if (cyc_no < 512) begin
            rec_addr[cyc_no]  = bus.imem_addr;
            rec_pc[cyc_no]    = bus.pc;
            rec_ld[cyc_no]    = bus.ld_data;
            rec_ireq[cyc_no]  = bus.imem_req;
            rec_dreq[cyc_no]  = bus.dmem_req;
            rec_rfw[cyc_no]   = bus.rf_wen;
            rec_halt[cyc_no]  = bus.halt;
            rec_cause[cyc_no] = bus.halt_cause;
        end
`ifdef NPC_PERF_CNT_EN
        chk({ph, "_perf"}, {64'd0, perf_cycle, perf_instret}, {64'd0, m_cyc, m_ret});
`endif
        if (!m_halt) m_cyc++;
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        #1;
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_inst", bus.inst, 32'h0000_0013);
        chk("rst_ld", bus.ld_data, 0);
        chk("rst_outs", {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.inst_valid, bus.rf_wen,
                         bus.halt, bus.halt_cause}, 0);
`ifdef NPC_PERF_CNT_EN
        chk("rst_perf", {perf_cycle, perf_instret}, 0);
`endif
        m_pc = RST_PC; m_inst = 32'h0000_0013; m_ld = 0; m_halt = 0; m_cause = 0;
        m_cyc = 0; m_ret = 0;
        d_load = 0; d_store = 0; d_wen = 0; d_ebreak = 0; d_br = 0; d_tgt = 0;
        bus.imem_gnt = 0; bus.imem_rvalid = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        skip   = 1'b1;
        cyc_no = 0;
    endtask

    // kind: 0 ALU/branch, 1 load, 2 store, 3 ebreak
    task automatic instr(input logic [31:0] word, input int kind, input bit wen, input bit br,
                         input logic [31:0] tgt, input logic [31:0] ldat, input int gf,
                         input int ri, input int gd, input int rd, input bit noise,
                         input bit abort_mw);
        logic [31:0] nxt;
        logic [31:0] pc0;
        pc0 = m_pc;
        for (int i = 0; i <= gf; i++)
            cyc("fetch", i == gf, rb(noise), $urandom, rb(noise), rb(noise), $urandom, 1, 0, 0, 0, 0);
        for (int i = 0; i <= ri; i++)
            cyc("iwait", rb(noise), i == ri, (i == ri) ? word : $urandom, rb(noise), rb(noise),
                $urandom, 0, 0, 0, 0, 0);
        m_inst   = word;
        d_load   = (kind == 1) || (kind == 3 && noise);
        d_store  = (kind == 2);
        d_wen    = wen;
        d_ebreak = (kind == 3);
        d_br     = br;
        d_tgt    = tgt;
        cyc("exec", rb(noise), rb(noise), $urandom, rb(noise), rb(noise), $urandom, 0, 1, 0, 0, 0);
        if (kind == 3) begin
            m_halt  = 1'b1;
            m_cause = 2'b01;
            $display("instr pc=%h inst=%h kind=ebreak -> halt", pc0, word);
            return;
        end
        if (kind == 1 || kind == 2) begin
            for (int i = 0; i <= gd; i++)
                cyc("mreq", rb(noise), rb(noise), $urandom, i == gd, rb(noise), $urandom,
                    0, 0, 1, kind == 2, 0);
            for (int i = 0; i <= rd; i++) begin
                cyc("mwait", rb(noise), rb(noise), $urandom, rb(noise), i == rd,
                    (i == rd) ? ldat : $urandom, 0, 0, 0, 0, 0);
                if (abort_mw) begin
                    $display("instr pc=%h inst=%h reset asserted in MWAIT", pc0, word);
                    do_reset();
                    return;
                end
            end
            if (kind == 1) m_ld = ldat;
        end
        cyc("wb", rb(noise), rb(noise), $urandom, rb(noise), rb(noise), $urandom, 0, 0, 0, 0, wen);
        nxt = br ? tgt : (m_pc + 32'd4);
        if (nxt[1:0] != 2'b00) begin
            m_halt  = 1'b1;
            m_cause = 2'b10;
        end else begin
            m_pc = nxt;
            m_ret++;
        end
        $display("instr pc=%h inst=%h kind=%0d wen=%0d next=%h halt=%0d", pc0, word, kind, wen,
                 nxt, m_halt);
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            d_wen = 1'b1; d_load = rb(1); d_store = rb(1); d_ebreak = rb(1);
            cyc("halt", rb(1), 1'b1, $urandom, rb(1), rb(1), $urandom, 0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        int sum;
        int k, kind;
        bit br;
        logic [31:0] tgt;

        // Scenario A: three ALU ops then ebreak, zero-wait memories
        do_reset();
        instr(32'h0010_0093, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_first_fetch_addr", rec_addr[1], 32'h8000_0000);
        sum = 0;
        for (int i = 1; i <= 3; i++) sum += int'(rec_rfw[i]);
        chk("lit_rfwen_before_c4", sum, 0);
        chk("lit_rfwen_c4", rec_rfw[4], 1);
        instr($urandom, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_pc_c5", rec_pc[5], 32'h8000_0004);
        instr($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        instr(32'h0010_0073, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        halt_cycles(4);
        chk("lit_ebreak_halt", {rec_halt[16], rec_cause[16]}, 3'b101);
        sum = 0;
        for (int i = 13; i <= 20; i++) sum += int'(rec_rfw[i]);
        chk("lit_ebreak_no_rfwen", sum, 0);
`ifdef NPC_PERF_CNT_EN
        chk("lit_perf_cycle", perf_cycle, 64'd15);
        chk("lit_perf_instret", perf_instret, 64'd3);
`endif

        // Scenario B: slow-grant load, taken branch, misaligned branch
        do_reset();
        instr($urandom, 1, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, 3, 0, 0, 0);
        sum = 0;
        for (int i = 1; i <= 9; i++) sum += int'(rec_dreq[i]);
        chk("lit_dmem_req_cycles", sum, 4);
        chk("lit_ld_data", rec_ld[9], 32'hDEAD_BEEF);
        sum = 0;
        for (int i = 1; i <= 9; i++) sum += int'(rec_rfw[i]);
        chk("lit_load_rfwen_once", sum, 1);
        instr($urandom, 0, 1, 1, 32'h8000_0100, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_pc_after_load", rec_pc[10], 32'h8000_0004);
        instr($urandom, 0, 1, 1, 32'h8000_0102, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_branch_fetch_addr", rec_addr[14], 32'h8000_0100);
        halt_cycles(3);
        chk("lit_misaligned_halt", {rec_halt[18], rec_cause[18]}, 3'b110);
        chk("lit_misaligned_pc", rec_pc[18], 32'h8000_0100);
        sum = 0;
        for (int i = 18; i <= 20; i++) sum += int'(rec_ireq[i]);
        chk("lit_halt_no_fetch", sum, 0);

        // Scenario C: PC wrap at 2^32
        do_reset();
        instr($urandom, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
        instr($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        instr($urandom, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit_wrap_fetch_addr", rec_addr[9], 32'h0000_0000);

        // Scenario D: reset in the middle of a load's MWAIT
        do_reset();
        instr($urandom, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        instr($urandom, 1, 1, 0, 0, $urandom | 32'h1, 0, 0, 0, 0, 0, 0);
        instr($urandom, 1, 1, 0, 0, $urandom, 0, 0, 0, 2, 0, 1);

        // Randomized program with random handshake delays and spurious responses
        for (int n = 0; n < 120; n++) begin
            k    = $urandom_range(0, 19);
            kind = (k < 10) ? 0 : (k < 14) ? 1 : (k < 18) ? 2 : (k == 19) ? 3 : 0;
            br   = ($urandom_range(0, 3) == 0);
            tgt  = {16'h8000, 14'($urandom), 2'b00};
            if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            instr($urandom, kind, 1'($urandom), br, tgt, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), 1, 0);
            if (m_halt) begin
                halt_cycles(2);
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
